lsu: RTL and testbench
======================

# lsu

Load-store unit for the RV32I execute stage. It takes the effective address produced by the ALU's `ALU_ADD` result, together with the store data and access size from the decoder. It drives a single-outstanding request/grant/rvalid data-memory port and returns aligned, sign- or zero-extended load data to writeback. Misaligned or illegal-size accesses are rejected without touching memory.

## Interface
- `RISCV_WORD_WIDTH`, 32, data and address width; only 32 is supported.
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  1  execute stage presents an access.
- `req_ready_o`  out  1  LSU can accept; high only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `unsigned_i`  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- `addr_i`  in  32  effective byte address (ALU result).
- `wdata_i`  in  32  store data (rs2), right-justified.
- `rsp_valid_o`  out  1  one-cycle pulse: access finished.
- `rdata_o`  out  32  extended load data; 0 for stores and errors.
- `misaligned_o`  out  1  qualifies `rsp_valid_o`: access rejected.
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory accepted request.
- `data_addr_o`  out  32  word address `{addr[31:2],2'b00}`.
- `data_we_o`  out  1  write enable.
- `data_be_o`  out  4  byte enables.
- `data_wdata_o`  out  32  lane-replicated store data.
- `data_rvalid_i`  in  1  read data / store ack valid.
- `data_rdata_i`  in  32  read word.

## Operation
- **FSM states:** IDLE, REQ, RESP, ERR.
  - IDLE: `req_ready_o` = 1. On `req_valid_i`, capture `we`, `size`, `unsigned`, `addr[1:0]`, address and data.
    - Misaligned access goes to ERR.
    - Otherwise go to REQ.
  - REQ: `data_req_o` = 1 with stable address, we, be and wdata. Go to RESP on `data_gnt_i`; otherwise hold.
  - RESP: wait for `data_rvalid_i`, then go to IDLE and register the response.
  - ERR: go to IDLE after one cycle and register the error response.
- **Misaligned** when any of these hold:
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - `size_i` = 11.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << addr[1:0]`;
  - word: `4'b1111`.
- **Store data:**
  - byte: `{4{wdata[7:0]}}`;
  - half: `{2{wdata[15:0]}}`;
  - word: `wdata` unchanged.
- **Load data:**
  - Shift `data_rdata_i` right by `8*addr[1:0]`.
  - Take the low 8 or 16 bits and extend per `unsigned_i`. A word is passed through.
- **Stores** also complete on `data_rvalid_i`; `rdata_o` = 0.
- **Memory protocol:**
  - `data_rvalid_i` outside RESP is ignored.
  - Memory asserts rvalid no earlier than the cycle after gnt.
  - Only one transaction is outstanding at a time.

## Timing
- **Reset values:**
  - state IDLE;
  - `req_ready_o` = 1;
  - `rsp_valid_o`, `misaligned_o`, `data_req_o`, `data_we_o` = 0;
  - `rdata_o`, `data_addr_o`, `data_wdata_o` = 0;
  - `data_be_o` = 0000.
- **Latency, memory access:** E0 = accepting edge.
  - `data_req_o` rises after E0.
  - With gnt on E1 and rvalid on E2, `rsp_valid_o` is high during the cycle E2–E3.
  - Each gnt or rvalid wait cycle adds one cycle.
- **Latency, misaligned:** `rsp_valid_o` and `misaligned_o` are high during E1–E2, and `data_req_o` never asserts.
- `rsp_valid_o`, `rdata_o` and `misaligned_o` are registered, one-cycle pulses. `rdata_o` holds its value until the next response.
- A new request may be accepted in the same cycle `rsp_valid_o` is high, because the FSM is already in IDLE.
- **Back-to-back memory accesses:** throughput is 1 per 3 cycles at best.
- **Reset mid-transaction:**
  - state returns to IDLE, all outputs take their reset values, and `data_req_o` drops after the reset edge;
  - an rvalid arriving afterwards is ignored;
  - no `rsp_valid_o` is issued.

## Test plan
- **LW, zero-wait:** addr 0x100, gnt on E1, rvalid on E2 with rdata 0xDEADBEEF → `data_addr_o` 0x100, be 1111, `rsp_valid_o` high E2–E3, `rdata_o` 0xDEADBEEF.
- **LB / LBU:** addr 0x103, rdata 0x80FF_0000 → be 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at addr 0x102 with the same rdata gives 0xFFFF80FF.
- **SB:** addr 0x201, wdata 0x12345678 → `data_addr_o` 0x200, be 0010, wdata 0x78787878, we 1. On rvalid, `rdata_o` = 0.
- **Misaligned:** LW at 0x102, SH at 0x1, then size 11 → each gives `rsp_valid_o` and `misaligned_o` for one cycle at E1, with no `data_req_o`.
- **Stalls:** gnt withheld 3 cycles → address, be and wdata stable while `data_req_o` is high. Rvalid delayed 2 cycles → response on the rvalid edge, `req_ready_o` low throughout.
- **Reset in RESP:** assert `rst_i` before rvalid → IDLE, `req_ready_o` = 1. A later rvalid produces no `rsp_valid_o`. A following LW completes normally.

Source files
------------

// File: rtl/lsu_if.sv
// Handshake and data-memory bus bundle for the load-store unit.
// master is the LSU side; slave is the execute-stage/memory environment.
interface lsu_if #(parameter int W = 32);
  logic         req_valid_i;
  logic         req_ready_o;
  logic         we_i;
  logic [1:0]   size_i;
  logic         unsigned_i;
  logic [W-1:0] addr_i;
  logic [W-1:0] wdata_i;
  logic         rsp_valid_o;
  logic [W-1:0] rdata_o;
  logic         misaligned_o;
  logic         data_req_o;
  logic         data_gnt_i;
  logic [W-1:0] data_addr_o;
  logic         data_we_o;
  logic [3:0]   data_be_o;
  logic [W-1:0] data_wdata_o;
  logic         data_rvalid_i;
  logic [W-1:0] data_rdata_i;

  modport master (
    input  req_valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
           data_gnt_i, data_rvalid_i, data_rdata_i,
    output req_ready_o, rsp_valid_o, rdata_o, misaligned_o,
           data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
  );

  modport slave (
    output req_valid_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
           data_gnt_i, data_rvalid_i, data_rdata_i,
    input  req_ready_o, rsp_valid_o, rdata_o, misaligned_o,
           data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
  );
endinterface

// File: rtl/lsu.sv
// RV32I load-store unit: single-outstanding req/gnt/rvalid data port,
// lane steering for stores, aligned sign/zero extension for loads.
module lsu #(
  parameter int RISCV_WORD_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  lsu_if.master bus
);
  localparam int W = RISCV_WORD_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]   r_state;
  logic         r_we;
  logic [1:0]   r_size;
  logic         r_uns;
  logic [1:0]   r_off;
  logic [W-1:0] r_addr;
  logic [3:0]   r_be;
  logic [W-1:0] r_wdata;
  logic         r_rsp_valid;
  logic         r_mis;
  logic [W-1:0] r_rdata;

  logic         w_mis;
  logic [3:0]   w_be;
  logic [W-1:0] w_wdata;
  logic [W-1:0] w_shift;
  logic [W-1:0] w_ldata;

  always_comb begin
    w_mis   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = bus.wdata_i;
    case (bus.size_i)
      2'b00: begin
        w_be    = 4'b0001 << bus.addr_i[1:0];
        w_wdata = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        w_mis   = bus.addr_i[0];
        w_be    = 4'b0011 << bus.addr_i[1:0];
        w_wdata = {2{bus.wdata_i[15:0]}};
      end
      2'b10: begin
        w_mis = |bus.addr_i[1:0];
        w_be  = 4'b1111;
      end
      default: w_mis = 1'b1;
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  always_comb begin
    w_shift = bus.data_rdata_i >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_ldata = {{(W-8){~r_uns & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ldata = {{(W-16){~r_uns & w_shift[15]}}, w_shift[15:0]};
      default: w_ldata = w_shift;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_off       <= 2'b00;
      r_addr      <= '0;
      r_be        <= 4'b0000;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_mis       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_mis       <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.req_valid_i) begin
          r_size <= bus.size_i;
          r_uns  <= bus.unsigned_i;
          r_off  <= bus.addr_i[1:0];
          if (w_mis) begin
            r_state <= S_ERR;
          end else begin
            // Bus fields only change for accesses that will reach memory.
            r_we    <= bus.we_i;
            r_addr  <= {bus.addr_i[W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_state <= S_REQ;
          end
        end
        S_REQ: if (bus.data_gnt_i) r_state <= S_RESP;
        S_RESP: if (bus.data_rvalid_i) begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b1;
          r_rdata     <= r_we ? '0 : w_ldata;
        end
        S_ERR: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b1;
          r_mis       <= 1'b1;
          r_rdata     <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (r_state == S_IDLE);
  assign bus.data_req_o   = (r_state == S_REQ);
  assign bus.data_addr_o  = r_addr;
  assign bus.data_we_o    = r_we;
  assign bus.data_be_o    = r_be;
  assign bus.data_wdata_o = r_wdata;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.misaligned_o = r_mis;
  assign bus.rdata_o      = r_rdata;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, stall/reset sequences and
// randomized accesses against a byte-lane reference model.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.W(32)) bus ();
  lsu #(.RISCV_WORD_WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: access covers nb consecutive bytes starting at addr%4.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int nb, off;
    longint val;
    off = int'(v.addr % 4);
    nb = (v.size == 2'd3) ? 0 : (1 << v.size);
    r.mis = (nb == 0) || ((off % nb) != 0);
    r.e_addr = v.addr - off;
    r.e_be = 4'b0;
    r.e_wdata = 32'h0;
    r.e_rdata = 32'h0;
    if (!r.mis) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) r.e_be[i] = 1'b1;
        r.e_wdata = r.e_wdata | (((v.wdata >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      end
      if (!v.we) begin
        val = longint'(v.rdata >> (8 * off));
        if (nb < 4) begin
          val = val % (longint'(1) << (8 * nb));
          if (!v.uns && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
        end
        r.e_rdata = val[31:0];
      end
    end
    return r;
  endfunction

  // Entered #1 after an edge; returns #1 after the response edge.
  task automatic run(input vec_t v, input int gw, input int rw, input string tag);
    chk({tag, " ready"}, {31'b0, bus.req_ready_o}, 32'h1);
    bus.req_valid_i = 1'b1;
    bus.we_i = v.we; bus.size_i = v.size; bus.unsigned_i = v.uns;
    bus.addr_i = v.addr; bus.wdata_i = v.wdata;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.addr_i = $urandom; bus.wdata_i = $urandom; bus.size_i = 2'($urandom);
    chk({tag, " rsp_idle"}, {31'b0, bus.rsp_valid_o}, 32'h0);
    chk({tag, " rdata_hold"}, bus.rdata_o, last_rdata);
    if (v.mis) begin
      chk({tag, " no_req"}, {31'b0, bus.data_req_o}, 32'h0);
      @(posedge clk); #1;
      chk({tag, " err_rsp"}, {31'b0, bus.rsp_valid_o}, 32'h1);
      chk({tag, " err_mis"}, {31'b0, bus.misaligned_o}, 32'h1);
      chk({tag, " err_rdata"}, bus.rdata_o, 32'h0);
      chk({tag, " err_no_req"}, {31'b0, bus.data_req_o}, 32'h0);
      last_rdata = 32'h0;
      return;
    end
    for (int i = 0; i <= gw; i++) begin
      chk({tag, " req"}, {31'b0, bus.data_req_o}, 32'h1);
      chk({tag, " addr"}, bus.data_addr_o, v.e_addr);
      chk({tag, " be"}, {28'b0, bus.data_be_o}, {28'b0, v.e_be});
      chk({tag, " we"}, {31'b0, bus.data_we_o}, {31'b0, v.we});
      chk({tag, " wdata"}, bus.data_wdata_o, v.e_wdata);
      chk({tag, " busy"}, {31'b0, bus.req_ready_o}, 32'h0);
      if (i == gw) bus.data_gnt_i = 1'b1;
      @(posedge clk); #1;
      bus.data_gnt_i = 1'b0;
    end
    chk({tag, " req_drop"}, {31'b0, bus.data_req_o}, 32'h0);
    for (int i = 0; i < rw; i++) begin
      chk({tag, " wait_rsp"}, {31'b0, bus.rsp_valid_o}, 32'h0);
      chk({tag, " wait_busy"}, {31'b0, bus.req_ready_o}, 32'h0);
      @(posedge clk); #1;
    end
    chk({tag, " wait_busy"}, {31'b0, bus.req_ready_o}, 32'h0);
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = v.rdata;
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i = $urandom;
    chk({tag, " rsp"}, {31'b0, bus.rsp_valid_o}, 32'h1);
    chk({tag, " mis"}, {31'b0, bus.misaligned_o}, 32'h0);
    chk({tag, " rdata"}, bus.rdata_o, v.e_rdata);
    chk({tag, " ready_again"}, {31'b0, bus.req_ready_o}, 32'h1);
    last_rdata = v.e_rdata;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic mis, input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.mis = mis; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tbl[10];
  vec_t rv;

  initial begin
    bus.req_valid_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.data_gnt_i = 1'b0;
    bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;

    //          we    sz     uns   addr          wdata         rdata         mis   e_addr        be       e_wdata       e_rdata
    tbl[0] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    tbl[1] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80);
    tbl[2] = mk(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'h0000_0080);
    tbl[3] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1100, 32'h0000_0000, 32'hFFFF_80FF);
    tbl[4] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0000_0200, 4'b0010, 32'h7878_7878, 32'h0000_0000);
    tbl[5] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
    tbl[6] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'hAAAA_5555, 32'h1111_1111, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
    tbl[7] = mk(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0);
    tbl[8] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1100, 32'h0000_0000, 32'h0000_80FF);
    tbl[9] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hAABB_1234, 32'h0BAD_0BAD, 1'b0, 32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0000_0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, bus.req_ready_o}, 32'h1);
    chk("rst rsp", {31'b0, bus.rsp_valid_o}, 32'h0);
    chk("rst mis", {31'b0, bus.misaligned_o}, 32'h0);
    chk("rst req", {31'b0, bus.data_req_o}, 32'h0);
    chk("rst we", {31'b0, bus.data_we_o}, 32'h0);
    chk("rst rdata", bus.rdata_o, 32'h0);
    chk("rst addr", bus.data_addr_o, 32'h0);
    chk("rst wdata", bus.data_wdata_o, 32'h0);
    chk("rst be", {28'b0, bus.data_be_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each run accepts in the cycle the previous response is up.
    foreach (tbl[i]) run(tbl[i], 0, 0, $sformatf("vec%0d", i));

    run(tbl[0], 3, 0, "gnt_stall");
    run(tbl[4], 0, 2, "rv_stall");
    run(tbl[3], 2, 1, "both_stall");

    // Stray rvalid while idle must not produce a response.
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b0;
    chk("stray_rv rsp", {31'b0, bus.rsp_valid_o}, 32'h0);

    // Reset while waiting for rvalid.
    bus.req_valid_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'b10; bus.addr_i = 32'h300;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.data_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.data_gnt_i = 1'b0;
    chk("rst_resp busy", {31'b0, bus.req_ready_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_resp ready", {31'b0, bus.req_ready_o}, 32'h1);
    chk("rst_resp req", {31'b0, bus.data_req_o}, 32'h0);
    chk("rst_resp addr", bus.data_addr_o, 32'h0);
    chk("rst_resp be", {28'b0, bus.data_be_o}, 32'h0);
    chk("rst_resp rdata", bus.rdata_o, 32'h0);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.data_rvalid_i = 1'b0;
    chk("rst_resp late_rv", {31'b0, bus.rsp_valid_o}, 32'h0);
    @(posedge clk); #1;
    chk("rst_resp late_rv2", {31'b0, bus.rsp_valid_o}, 32'h0);
    last_rdata = 32'h0;
    run(tbl[0], 0, 0, "post_rst_lw");

    for (int k = 0; k < 80; k++) begin
      rv.we = 1'($urandom); rv.size = 2'($urandom); rv.uns = 1'($urandom);
      rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
      rv = model(rv);
      run(rv, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
